// File: rtl/branch_target_predictor.sv
// Fetch-stage branch target buffer with 2-bit direction counters.
// Predicts from the I-stage PC, tracks each prediction through R and C, and
// trains from R-stage jump and C-stage branch/jump resolutions.
// Optional statistics counters are enabled by defining BTB_STATS_EN.

`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module branch_target_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned TAG_W   = `BIT_COUNT - IDX_W - 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  StallI,
    input  logic                  StallR,
    input  logic                  FlushIR,
    input  logic                  FlushRC,
    input  logic [`BIT_COUNT-1:0] PC_I,
    input  logic [`BIT_COUNT-1:0] PCpImm_R,
    input  logic                  IsJumpR_R,
    input  logic                  ValidC,
    input  logic                  IsBranch_C,
    input  logic                  IsJumpC_C,
    input  logic                  Taken_C,
    input  logic [`BIT_COUNT-1:0] Target_C,
`ifdef BTB_STATS_EN
    output logic [31:0]           LookupHits,
    output logic [31:0]           Mispredicts,
`endif
    output logic                  Predict,
    output logic [`BIT_COUNT-1:0] Prediction,
    output logic                  PredictionCorrect_R,
    output logic                  PredictionCorrect_C
);

    localparam int unsigned W = `BIT_COUNT;

    // Table storage
    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [W-1:1]     tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];
    logic             tbl_jump   [ENTRIES];

    // Pipeline prediction slots; PC bits [1:0] are never needed
    logic         r_v, r_pred, c_v, c_pred;
    logic [W-1:0] r_target, c_target;
    logic [W-1:2] r_pc, c_pc;

    logic [IDX_W-1:0] idx_i, idx_c, idx_r;
    logic [TAG_W-1:0] tag_i, tag_c, tag_r;
    logic             hit_i, hit_c;
    logic             c_act, c_upd, r_upd;

    logic unused_bits;
    assign unused_bits = ^{PC_I[1:0], PCpImm_R[0], Target_C[0]};

    assign idx_i = PC_I[IDX_W+1:2];
    assign tag_i = PC_I[W-1:IDX_W+2];
    assign idx_c = c_pc[IDX_W+1:2];
    assign tag_c = c_pc[W-1:IDX_W+2];
    assign idx_r = r_pc[IDX_W+1:2];
    assign tag_r = r_pc[W-1:IDX_W+2];

    // Combinational lookup and resolution checks
    always_comb begin
        hit_i      = tbl_valid[idx_i] && (tbl_tag[idx_i] == tag_i);
        Predict    = hit_i && (tbl_jump[idx_i] || tbl_ctr[idx_i][1]);
        Prediction = Predict ? {tbl_target[idx_i], 1'b0} : '0;
        hit_c      = tbl_valid[idx_c] && (tbl_tag[idx_c] == tag_c);

        PredictionCorrect_R = r_v && IsJumpR_R && r_pred &&
                              (r_target == {PCpImm_R[W-1:1], 1'b0});

        c_act = ValidC && c_v && (IsBranch_C || IsJumpC_C);
        PredictionCorrect_C = c_act && (Taken_C == c_pred) &&
                              (!Taken_C || (c_target == {Target_C[W-1:1], 1'b0}));

        c_upd = c_act && !StallR;
        // C-stage training wins; a dropped R-stage jump retrains next time
        r_upd = r_v && IsJumpR_R && !PredictionCorrect_R && !StallR && !c_upd;
    end

    // I->R and R->C prediction slots; flush clears valid ahead of any load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v      <= 1'b0;
            r_pred   <= 1'b0;
            r_target <= '0;
            r_pc     <= '0;
            c_v      <= 1'b0;
            c_pred   <= 1'b0;
            c_target <= '0;
            c_pc     <= '0;
        end else begin
            if (FlushIR)      r_v <= 1'b0;
            else if (!StallI) r_v <= 1'b1;
            if (!StallI) begin
                r_pred   <= Predict;
                r_target <= Prediction;
                r_pc     <= PC_I[W-1:2];
            end
            if (FlushRC)      c_v <= 1'b0;
            else if (!StallR) c_v <= r_v;
            if (!StallR) begin
                c_pred   <= r_pred;
                c_target <= r_target;
                c_pc     <= r_pc;
            end
        end
    end

    // Table training from C-stage resolutions, else R-stage jump misses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_valid[i]  <= 1'b0;
                tbl_tag[i]    <= '0;
                tbl_target[i] <= '0;
                tbl_ctr[i]    <= 2'b01;
                tbl_jump[i]   <= 1'b0;
            end
        end else if (c_upd) begin
            if (hit_c) begin
                if (Taken_C) begin
                    if (tbl_ctr[idx_c] != 2'b11) tbl_ctr[idx_c] <= tbl_ctr[idx_c] + 2'd1;
                    tbl_target[idx_c] <= Target_C[W-1:1];
                end else if (tbl_ctr[idx_c] != 2'b00) begin
                    tbl_ctr[idx_c] <= tbl_ctr[idx_c] - 2'd1;
                end
            end else if (Taken_C) begin
                tbl_valid[idx_c]  <= 1'b1;
                tbl_tag[idx_c]    <= tag_c;
                tbl_target[idx_c] <= Target_C[W-1:1];
                tbl_ctr[idx_c]    <= 2'b10;
                tbl_jump[idx_c]   <= IsJumpC_C;
            end
        end else if (r_upd) begin
            tbl_valid[idx_r]  <= 1'b1;
            tbl_tag[idx_r]    <= tag_r;
            tbl_target[idx_r] <= PCpImm_R[W-1:1];
            tbl_ctr[idx_r]    <= 2'b11;
            tbl_jump[idx_r]   <= 1'b1;
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] hits_q, misp_q;

    // Lookup-hit and misprediction counters, free-running and wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hits_q <= '0;
            misp_q <= '0;
        end else begin
            if (!StallI && hit_i)               hits_q <= hits_q + 32'd1;
            if (c_upd && !PredictionCorrect_C)  misp_q <= misp_q + 32'd1;
        end
    end

    assign LookupHits  = hits_q;
    assign Mispredicts = misp_q;
`endif

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Fetch-stage branch target buffer (BTB) with 2-bit direction counters.
- Looks up the I-stage PC and drives Predict/Prediction into the PC update handler.
- Carries each prediction down the I→R→C pipeline. Produces PredictionCorrect_R for R-stage jumps and PredictionCorrect_C for C-stage branches and jumps.
- Trains its table from the R-stage and C-stage resolutions.

Parameters:
- ENTRIES, 16, number of direct-mapped BTB entries; must be a power of 2, at least 2.
- IDX_W, $clog2(ENTRIES), index width.
- TAG_W, `BIT_COUNT-IDX_W-2, stored tag width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- StallI  in  1  hold the I→R pipeline registers.
- StallR  in  1  hold the R→C pipeline registers.
- FlushIR  in  1  from the PC update handler; invalidates the R-stage prediction slot.
- FlushRC  in  1  from the PC update handler; invalidates the C-stage prediction slot.
- PC_I  in  `BIT_COUNT  current fetch PC.
- PCpImm_R  in  `BIT_COUNT  R-stage jump target.
- IsJumpR_R  in  1  R-stage instruction is a Jump_R type.
- ValidC  in  1  C stage holds a live instruction.
- IsBranch_C  in  1  C-stage instruction is a conditional branch.
- IsJumpC_C  in  1  C-stage instruction is a register jump.
- Taken_C  in  1  branch resolved taken; forced 1 for jumps.
- Target_C  in  `BIT_COUNT  resolved C-stage target.
- Predict  out  1  I-stage predicted-taken.
- Prediction  out  `BIT_COUNT  I-stage predicted target, bit 0 = 0.
- PredictionCorrect_R  out  1  R-stage jump was already predicted to the correct target.
- PredictionCorrect_C  out  1  C-stage branch/jump was predicted correctly in both direction and target.

Behaviour:
- Address split:
  - idx = PC[IDX_W+1:2]
  - tag = PC[`BIT_COUNT-1:IDX_W+2]
- Each entry holds: valid, tag, target[`BIT_COUNT-1:1], ctr[1:0], isJump.
- Lookup is combinational from PC_I.
  - hit = valid & tag match.
  - Predict = hit & (isJump | ctr[1]).
  - Prediction = {target, 1'b0} when Predict, else 0.
- Pipeline slots R and C each hold: V, Pred, Target, PC.
  - Slot R loads from the I-stage lookup on each clk when ~StallI.
  - Slot C loads from slot R on each clk when ~StallR.
  - FlushIR clears R.V on that edge and has priority over load. FlushRC clears C.V likewise.
  - A stall holds the slot's contents unchanged.
- PredictionCorrect_R = R.V & IsJumpR_R & R.Pred & (R.Target == {PCpImm_R[`BIT_COUNT-1:1],1'b0}). Combinational.
- PredictionCorrect_C is combinational. It is 0 unless ValidC & C.V & (IsBranch_C | IsJumpC_C). When enabled:
  - It is 1 if Taken_C == C.Pred and either ~Taken_C or C.Target == {Target_C[`BIT_COUNT-1:1],1'b0}.
  - Otherwise it is 0.
- C-stage update fires on the edge where ValidC & C.V & (IsBranch_C|IsJumpC_C) & ~StallR, at the entry indexed by C.PC.
  - Hit and taken: ctr saturating +1 (max 2'b11); target rewritten.
  - Hit and not taken: ctr saturating −1 (min 2'b00).
  - Miss and taken: allocate the entry with valid=1, the C.PC tag, ctr=2'b10, the target, and isJump=IsJumpC_C.
  - Miss and not taken: no write.
- R-stage update fires when R.V & IsJumpR_R & ~PredictionCorrect_R & ~StallR. It allocates or overwrites the R.PC entry with target=PCpImm_R, isJump=1, ctr=2'b11.
- If the C-stage and R-stage updates fire in the same cycle:
  - The C update wins.
  - The R update is dropped; it retrains on the next encounter.
- Write/read on the same index in the same cycle: the lookup sees the pre-write contents. The write takes effect at the clk edge.
- Reset (reset_n low, asynchronous), any cycle including mid-update:
  - All valid bits = 0; all ctr = 2'b01.
  - R.V = C.V = 0; Pred and Target = 0.
  - Outputs: Predict=0, Prediction=0, PredictionCorrect_R=0, PredictionCorrect_C=0.
- Latency: prediction is 0 cycles (same-cycle combinational). A trained entry is visible to a lookup from the cycle after its update edge.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds output ports LookupHits[31:0] and Mispredicts[31:0].
  - LookupHits increments on each ~StallI edge with a hit.
  - Mispredicts increments on each C-stage update edge where PredictionCorrect_C=0.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: no ports and no counter logic.

Test Plan:
- Reset then lookup PC_I=0x100 → Predict=0, Prediction=0, all corrects 0.
- C-stage taken branch at PC 0x100, Target_C 0x180, miss:
  - That cycle PredictionCorrect_C=0.
  - Next cycle, PC_I=0x100 → Predict=1, Prediction=0x180.
- Same branch resolved not-taken twice → ctr goes 10→01→00; PC_I=0x100 → Predict=0.
- Jump_R at 0x200 to 0x240, unpredicted → PredictionCorrect_R=0 and the entry is allocated. On re-fetch: Predict=1, Prediction=0x240; in R, PredictionCorrect_R=1.
- Predicted entry flowing into R with FlushIR=1 → next cycle R.V=0 and PredictionCorrect_R=0 even with a matching PCpImm_R.
- C-stage update and R-stage allocate in the same cycle at different PCs → only the C entry is written; the R PC still misses next cycle.
